bcd_display_encoder: RTL and testbench
======================================

Name: bcd_display_encoder

Overview:
Parametrised successor to the single-cycle display encoder. It converts NUM_FIELDS packed binary fields (for example hour, minute and second) into per-field BCD digit nibbles for the seven-segment driver. Conversion uses a sequential shift-add-3 (double-dabble) engine in place of combinational /10 and %10, and all fields are converted in parallel. Adds a valid/ready input handshake, per-field overflow saturation and runtime leading-zero blanking. Sits between the time/date counter block and the display scan/segment driver.

Parameters:
- NUM_FIELDS, 3, number of independent binary fields converted in parallel.
- FIELD_W, 8, bit width of each binary field.
- DIGITS, 2, BCD digits output per field, least significant digit first within the field.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block is idle and can accept in_data.
- in_data  in  NUM_FIELDS*FIELD_W  packed fields, field 0 in the LSBs.
- blank_en  in  1  leading-zero blanking enable; sampled at accept.
- out_valid  out  1  single-cycle pulse: out_digits and out_ovf updated.
- out_digits  out  NUM_FIELDS*DIGITS*4  field f, digit d at bit offset (f*DIGITS+d)*4.
- out_ovf  out  NUM_FIELDS  field value is >= 10**DIGITS.
- busy  out  1  conversion in progress.

Behaviour:
- Reset values: in_ready=1, out_valid=0, out_digits=0, out_ovf=0, busy=0, FSM=IDLE, all lane registers 0.
- FSM states are IDLE, SHIFT and LOAD.
- IDLE: in_ready=1. If in_valid, then on that edge: capture in_data and blank_en, clear BCD accumulators, load bit counter with FIELD_W-1, go to SHIFT.
- SHIFT: in_ready=0, busy=1. On each edge, every lane adds 3 to each BCD digit that is >=5, then shifts the MSB of the binary field in. When the bit counter reaches 0, go to LOAD. SHIFT lasts FIELD_W cycles.
- LOAD: busy=1. On this edge, register the formatted result into out_digits/out_ovf, pulse out_valid for the next cycle, and return to IDLE.
- Latency: out_valid is high during the cycle beginning FIELD_W+1 edges after the accept edge. The default is 9 edges.
- Throughput: one conversion per FIELD_W+2 cycles. in_ready is high in the same cycle as out_valid, so back-to-back conversions are allowed.
- Internal BCD width: FULL_DIGITS = number of decimal digits of 2**FIELD_W-1 (3 for FIELD_W=8).
- Overflow: if any internal digit at index >= DIGITS is non-zero, set out_ovf[f]=1 and force all DIGITS digits of field f to 4'h9. This applies only when FULL_DIGITS > DIGITS.
- Blanking (captured blank_en=1, field not overflowed): scan from the most significant digit down. Each leading 0 digit is replaced by BLANK_CODE (4'hF). Digit 0 is never blanked, so a value of 0 shows "F0" for DIGITS=2.
- out_digits and out_ovf hold their values until the next LOAD. There is no output backpressure; the consumer must sample on out_valid or read the held value.
- in_valid while in_ready=0 is ignored. There is no queuing; the source holds in_valid until accepted.
- Changes on in_data or blank_en after the accept edge have no effect on the current conversion.
- rst_n asserted mid-conversion: everything returns to reset values immediately. The partial result is discarded and no out_valid is produced.
- in_data field values are unsigned; the full range 0..2**FIELD_W-1 is legal.

Decomposition:
- Package bcd_pkg contains:
  - BLANK_CODE = 4'hF;
  - typedef enum state_t {IDLE, SHIFT, LOAD};
  - a constant function dec_digits(width) returning the digit count of 2**width-1.
- Sub-module bcd_dd_lane holds one field's binary shift register and FULL_DIGITS BCD accumulator with the add-3/shift step.
  - Parameters: FIELD_W, FULL_DIGITS.
  - Controls: load and shift_en.
  - Output: raw BCD.
- The top instantiates NUM_FIELDS lanes via a generate loop and owns the FSM, bit counter, and overflow/blanking formatting.

Test Plan:
- Defaults, in_data={8'd23,8'd59,8'd7}, blank_en=0, single accept → out_valid exactly 9 edges later; out_digits=24'h235907; out_ovf=0; in_ready low for the 8 SHIFT cycles plus LOAD.
- Field0=8'd200, field1=8'd255, field2=8'd99 → field0 and field1 digits = 8'h99 with out_ovf=3'b011; field2 = 8'h99 with ovf bit 0.
- blank_en=1, fields {8'd0,8'd5,8'd40} → out_digits=24'hF0F540, out_ovf=0. A repeat with blank_en=0 gives 24'h000540.
- in_valid held high continuously with alternating data → accepts spaced exactly FIELD_W+2 cycles apart; each out_valid carries the matching result; in_data changes while busy do not corrupt the output.
- rst_n pulsed low at SHIFT cycle 4 → all outputs return to reset values asynchronously; no out_valid; the next conversion after release is correct.
- Parameter variant FIELD_W=10, DIGITS=3, NUM_FIELDS=2, fields {10'd1023,10'd999} → out_digits=24'h999999, out_ovf=2'b10; latency 11 edges.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD display encoder: state encoding,
// blank digit code and decimal-width helper.
package bcd_pkg;

   localparam logic [3:0] BLANK_CODE = 4'hF;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      LOAD
   } state_t;

   // Number of decimal digits needed to show 2**width-1.
   function automatic int dec_digits(input int width);
      longint unsigned v;
      int              n;
      v = (64'd1 << width) - 64'd1;
      n = 1;
      while (v >= 64'd10) begin
         v = v / 64'd10;
         n++;
      end
      return n;
   endfunction

endpackage

// File: rtl/bcd_dd_lane.sv
// One double-dabble lane: binary shift register plus BCD accumulator,
// advanced one bit per shift_en cycle.
module bcd_dd_lane #(
   parameter int FIELD_W     = 8,
   parameter int FULL_DIGITS = 3
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     load,
   input  logic                     shift_en,
   input  logic [FIELD_W-1:0]       bin_in,
   output logic [FULL_DIGITS*4-1:0] bcd
);

   logic [FIELD_W-1:0]       bin_q, bin_d;
   logic [FULL_DIGITS*4-1:0] bcd_q, bcd_d, bcd_adj;

   // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
   always_comb begin
      bcd_adj = bcd_q;
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      for (int d = 0; d < FULL_DIGITS; d++) begin
         if (bcd_q[d*4 +: 4] >= 4'd5) bcd_adj[d*4 +: 4] = bcd_q[d*4 +: 4] + 4'd3;
      end
      if (load) begin
         bin_d = bin_in;
         bcd_d = '0;
      end else if (shift_en) begin
         {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
      end
   end

   // NOTE: the accumulators are a handful of flops, not a RAM, so they take the async reset like everything else.
   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bin_q <= '0;
         bcd_q <= '0;
      end else begin
         bin_q <= bin_d;
         bcd_q <= bcd_d;
      end
   end

   assign bcd = bcd_q;

endmodule

// File: rtl/bcd_display_encoder.sv
// Converts NUM_FIELDS packed binary fields to BCD digits with a sequential
// double-dabble engine, overflow saturation and leading-zero blanking.
module bcd_display_encoder
   import bcd_pkg::*;
#(
   parameter int NUM_FIELDS = 3,
   parameter int FIELD_W    = 8,
   parameter int DIGITS     = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [NUM_FIELDS*FIELD_W-1:0] in_data,
   input  logic                         blank_en,
   output logic                         out_valid,
   output logic [NUM_FIELDS*DIGITS*4-1:0] out_digits,
   output logic [NUM_FIELDS-1:0]        out_ovf,
   output logic                         busy
);

   localparam int FULL_DIGITS = dec_digits(FIELD_W);
   localparam int EXT_DIGITS  = (FULL_DIGITS > DIGITS) ? FULL_DIGITS : DIGITS;
   localparam int EXT_W       = EXT_DIGITS * 4;
   localparam int CNT_W       = (FIELD_W > 1) ? $clog2(FIELD_W) : 1;

   state_t                         state_q, state_d;
   logic [CNT_W-1:0]               cnt_q, cnt_d;
   logic                           blank_q, blank_d;
   logic                           out_valid_q, out_valid_d;
   logic [NUM_FIELDS*DIGITS*4-1:0] out_digits_q, out_digits_d;
   logic [NUM_FIELDS-1:0]          out_ovf_q, out_ovf_d;

   logic                           lane_load, lane_shift;
   logic [FULL_DIGITS*4-1:0]       lane_bcd [NUM_FIELDS];

   logic [NUM_FIELDS*DIGITS*4-1:0] fmt_digits;
   logic [NUM_FIELDS-1:0]          fmt_ovf;
   logic [EXT_W-1:0]               raw_ext;
   logic                           lead;
   logic [3:0]                     digit;

   for (genvar g = 0; g < NUM_FIELDS; g++) begin : g_lane
      bcd_dd_lane #(
         .FIELD_W    (FIELD_W),
         .FULL_DIGITS(FULL_DIGITS)
      ) u_lane (
         .clk     (clk),
         .rst_n   (rst_n),
         .load    (lane_load),
         .shift_en(lane_shift),
         .bin_in  (in_data[g*FIELD_W +: FIELD_W]),
         .bcd     (lane_bcd[g])
      );
   end

   // Saturate overflowed fields to all nines; otherwise blank leading zeros above digit 0.
   always_comb begin
      fmt_digits = '0;
      fmt_ovf    = '0;
      raw_ext    = '0;
      lead       = 1'b0;
      digit      = '0;
      for (int f = 0; f < NUM_FIELDS; f++) begin
         raw_ext = EXT_W'(lane_bcd[f]);
         lead    = blank_q;
         for (int d = DIGITS; d < EXT_DIGITS; d++) begin
            if (raw_ext[d*4 +: 4] != 4'd0) fmt_ovf[f] = 1'b1;
         end
         for (int d = DIGITS - 1; d >= 0; d--) begin
            digit = raw_ext[d*4 +: 4];
            if (fmt_ovf[f]) begin
               digit = 4'h9;
            end else if (lead && (d != 0) && (digit == 4'd0)) begin
               digit = BLANK_CODE;
            end else begin
               lead = 1'b0;
            end
            fmt_digits[(f*DIGITS+d)*4 +: 4] = digit;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      blank_d      = blank_q;
      out_valid_d  = 1'b0;
      out_digits_d = out_digits_q;
      out_ovf_d    = out_ovf_q;
      lane_load    = 1'b0;
      lane_shift   = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               lane_load = 1'b1;
               blank_d   = blank_en;
               cnt_d     = CNT_W'(FIELD_W - 1);
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            lane_shift = 1'b1;
            if (cnt_q == '0) state_d = LOAD;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         LOAD: begin
            out_digits_d = fmt_digits;
            out_ovf_d    = fmt_ovf;
            out_valid_d  = 1'b1;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         blank_q      <= 1'b0;
         out_valid_q  <= 1'b0;
         out_digits_q <= '0;
         out_ovf_q    <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         blank_q      <= blank_d;
         out_valid_q  <= out_valid_d;
         out_digits_q <= out_digits_d;
         out_ovf_q    <= out_ovf_d;
      end
   end

   assign in_ready   = (state_q == IDLE);
   assign busy       = (state_q != IDLE);
   assign out_valid  = out_valid_q;
   assign out_digits = out_digits_q;
   assign out_ovf    = out_ovf_q;

endmodule

// File: tb/tb_bcd_display_encoder.sv
// Scoreboard bench for bcd_display_encoder: default instance plus a
// FIELD_W=10 / DIGITS=3 / NUM_FIELDS=2 variant.
module tb_bcd_display_encoder;

   localparam int NF  = 3;
   localparam int FW  = 8;
   localparam int ND  = 2;
   localparam int VNF = 2;
   localparam int VFW = 10;
   localparam int VND = 3;

   logic              clk;
   logic              rst_n;
   logic              in_valid, in_ready, blank_en, out_valid, busy;
   logic [NF*FW-1:0]  in_data;
   logic [NF*ND*4-1:0] out_digits;
   logic [NF-1:0]     out_ovf;

   logic               v_in_valid, v_in_ready, v_blank_en, v_out_valid, v_busy;
   logic [VNF*VFW-1:0] v_in_data;
   logic [VNF*VND*4-1:0] v_out_digits;
   logic [VNF-1:0]     v_out_ovf;

   bcd_display_encoder #(.NUM_FIELDS(NF), .FIELD_W(FW), .DIGITS(ND)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .blank_en(blank_en), .out_valid(out_valid),
      .out_digits(out_digits), .out_ovf(out_ovf), .busy(busy)
   );

   bcd_display_encoder #(.NUM_FIELDS(VNF), .FIELD_W(VFW), .DIGITS(VND)) dut_v (
      .clk(clk), .rst_n(rst_n), .in_valid(v_in_valid), .in_ready(v_in_ready),
      .in_data(v_in_data), .blank_en(v_blank_en), .out_valid(v_out_valid),
      .out_digits(v_out_digits), .out_ovf(v_out_ovf), .busy(v_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [23:0] digits;
      logic [2:0]  ovf;
      int          acc;
   } exp_t;

   exp_t sb[$];
   int   acc_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;

   function automatic int pow10(input int n);
      int p = 1;
      for (int i = 0; i < n; i++) p = p * 10;
      return p;
   endfunction

   // Decimal formatting straight from the value: divide/modulo, compare with powers of ten.
   function automatic void enc(input logic [63:0] data, input int nf, input int fw, input int nd,
                               input bit blank, output logic [63:0] dg, output logic [7:0] ov);
      int v;
      dg = '0;
      ov = '0;
      for (int f = 0; f < nf; f++) begin
         v = int'((data >> (f * fw)) & ((64'd1 << fw) - 64'd1));
         ov[f] = (v >= pow10(nd));
         for (int d = 0; d < nd; d++) begin
            logic [3:0] x;
            if (ov[f])                            x = 4'h9;
            else if (blank && d > 0 && v < pow10(d)) x = 4'hF;
            else                                  x = 4'((v / pow10(d)) % 10);
            dg[(f*nd+d)*4 +: 4] = x;
         end
      end
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Expected results are queued at the accept edge from the driven stimulus.
   always @(negedge clk) begin
      if (rst_n && in_valid && in_ready) begin
         exp_t        e;
         logic [63:0] dg;
         logic [7:0]  ov;
         enc(64'(in_data), NF, FW, ND, blank_en, dg, ov);
         e.digits = dg[23:0];
         e.ovf    = ov[2:0];
         e.acc    = cyc + 1;
         sb.push_back(e);
         acc_q.push_back(cyc + 1);
      end
   end

   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         if (sb.size() == 0) begin
            check("unexpected_out_valid", 64'(out_valid), 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("digits", 64'(out_digits), 64'(e.digits));
            check("ovf", 64'(out_ovf), 64'(e.ovf));
            check("latency", 64'(cyc - e.acc), 64'(FW + 1));
         end
      end
   end

   task automatic send(input logic [23:0] d, input bit b);
      bit ok = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = d;
      blank_en = b;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      check("accept_timeout", 64'(ok), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = 24'($urandom);
      blank_en = 1'($urandom);
   endtask

   task automatic drain();
      for (int i = 0; i < 60; i++) begin
         if (sb.size() == 0) break;
         @(negedge clk);
      end
      check("drain_timeout", 64'(sb.size()), 64'd0);
   endtask

   task automatic vconv(input logic [19:0] d, input bit b);
      logic [63:0] dg;
      logic [7:0]  ov;
      int          n    = 0;
      bit          seen = 1'b0;
      enc(64'(d), VNF, VFW, VND, b, dg, ov);
      @(posedge clk); #1;
      v_in_valid = 1'b1;
      v_in_data  = d;
      v_blank_en = b;
      @(negedge clk);
      check("v_in_ready", 64'(v_in_ready), 64'd1);
      @(posedge clk); #1;
      v_in_valid = 1'b0;
      v_in_data  = 20'($urandom);
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
         if (v_out_valid) begin
            n    = i;
            seen = 1'b1;
            break;
         end
      end
      check("v_out_valid_seen", 64'(seen), 64'd1);
      check("v_latency", 64'(n - 1), 64'(VFW + 1));
      check("v_digits", 64'(v_out_digits), 64'(dg[23:0]));
      check("v_ovf", 64'(v_out_ovf), 64'(ov[1:0]));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
      check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_out_digits"}, 64'(out_digits), 64'd0);
      check({tag, "_out_ovf"}, 64'(out_ovf), 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      in_data    = '0;
      blank_en   = 1'b0;
      v_in_valid = 1'b0;
      v_in_data  = '0;
      v_blank_en = 1'b0;
      #23;
      check_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Basic conversion; in_ready/busy through the 8 SHIFT cycles and LOAD.
      send({8'd23, 8'd59, 8'd7}, 1'b0);
      for (int i = 0; i < FW + 1; i++) begin
         @(negedge clk);
         check("in_ready_busy_phase", 64'(in_ready), 64'd0);
         check("busy_busy_phase", 64'(busy), 64'd1);
      end
      @(negedge clk);
      check("in_ready_with_out_valid", 64'({in_ready, out_valid}), 64'b11);
      check("digits_235907", 64'(out_digits), 64'h235907);
      drain();

      send({8'd99, 8'd255, 8'd200}, 1'b0);
      drain();
      check("ovf_saturation", 64'({out_ovf, out_digits}), 64'h3_999999);
      send({8'd0, 8'd5, 8'd40}, 1'b1);
      drain();
      check("blank_on", 64'(out_digits), 64'hF0F540);
      send({8'd0, 8'd5, 8'd40}, 1'b0);
      drain();
      check("blank_off", 64'(out_digits), 64'h000540);
      send({8'd255, 8'd100, 8'd9}, 1'b1);
      send({8'd10, 8'd0, 8'd99}, 1'b1);

      for (int i = 0; i < 20; i++) send(24'($urandom), 1'($urandom));
      drain();

      // in_valid held high with data changing every cycle.
      acc_q.delete();
      @(posedge clk); #1;
      in_valid = 1'b1;
      for (int i = 0; i < 5 * (FW + 2); i++) begin
         in_data  = 24'($urandom);
         blank_en = 1'($urandom);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      drain();
      check("hold_accept_count", 64'(acc_q.size() >= 4), 64'd1);
      for (int i = 1; i < acc_q.size(); i++) begin
         check("accept_spacing", 64'(acc_q[i] - acc_q[i-1]), 64'(FW + 2));
      end

      // Reset in the middle of SHIFT.
      send({8'd123, 8'd45, 8'd67}, 1'b0);
      repeat (4) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midreset");
      sb.delete();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (15) @(negedge clk);
      check("post_reset_idle", 64'({in_ready, busy}), 64'b10);
      send({8'd42, 8'd8, 8'd199}, 1'b1);
      drain();

      // Wider-field variant.
      vconv({10'd1023, 10'd999}, 1'b0);
      vconv({10'd7, 10'd0}, 1'b1);
      vconv({10'd50, 10'd1000}, 1'b1);
      for (int i = 0; i < 4; i++) vconv(20'($urandom), 1'($urandom));

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
